speaker_arbiter: RTL

//  Shares the single speaker output between NUM_REQ tone sources (siren, chirp, beep generators).

---
 rtl/speaker_arbiter_pkg.sv | 40 ++++
 rtl/speaker_arbiter_down_timer.sv | 28 ++
 rtl/speaker_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/speaker_arbiter_pkg.sv
// Shared audio-subsystem constants: arbiter state encoding, clock-derived
// timing constants used by the tone generators, and the priority encoder.
package audio_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_OWN  = 2'd1;
  localparam logic [1:0] ARB_GAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_OWN  = ARB_OWN,
    ST_GAP  = ARB_GAP
  } arb_state_t;

  localparam int CLK_HZ        = 25_000_000;
  localparam int CYCLES_PER_MS = CLK_HZ / 1000;

  localparam int HOLD_MS  = 100;
  localparam int GAP_MS   = 10;
  localparam int BEEP_MS  = 50;
  localparam int CHIRP_MS = 20;

  localparam int HOLD_DEFAULT_CYCLES = HOLD_MS  * CYCLES_PER_MS;
  localparam int GAP_DEFAULT_CYCLES  = GAP_MS   * CYCLES_PER_MS;
  localparam int BEEP_CYCLES         = BEEP_MS  * CYCLES_PER_MS;
  localparam int CHIRP_CYCLES        = CHIRP_MS * CYCLES_PER_MS;

  // Widest requester vector the encoder accepts; callers zero-extend.
  localparam int MAX_REQ = 32;

  function automatic int prio_enc(input logic [MAX_REQ-1:0] reqVec);
    int idx;
    idx = 0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (reqVec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/speaker_arbiter_down_timer.sv
// Loadable down-counter that saturates at zero; expired is high whenever
// the count has reached zero.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_tick,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/speaker_arbiter.sv
// Fixed-priority speaker arbiter: index 0 wins, a minimum hold time limits
// preemption, and a silent guard gap separates consecutive owners.
module speaker_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = HOLD_DEFAULT_CYCLES,
  parameter int GAP_CYCLES  = GAP_DEFAULT_CYCLES
) (
  input  logic                       clock_25mhz,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         tone_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       audio_out
);

  localparam int IDW      = $clog2(NUM_REQ);
  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int MAX_T    = (HOLD_EFF > GAP_EFF) ? HOLD_EFF : GAP_EFF;
  localparam int TW       = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_EFF - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_EFF - 1);

  arb_state_t         r_state;
  logic [IDW-1:0]     r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDW-1:0]     r_grantId;
  logic               r_busy;
  logic               r_audio;

  arb_state_t         w_nextState;
  logic [IDW-1:0]     w_nextOwner;
  logic               w_holdLoad;
  logic               w_gapLoad;
  logic               w_holdExpired;
  logic               w_gapExpired;
  logic [MAX_REQ-1:0] w_reqExt;
  logic [IDW-1:0]     w_arbIdx;
  logic [NUM_REQ-1:0] w_lowerMask;
  logic               w_higherReq;
  logic               w_ownerReq;
  logic [NUM_REQ-1:0] w_nextGrant;
  logic [IDW-1:0]     w_nextGrantId;
  logic               w_nextBusy;
  logic               w_nextAudio;

  assign w_reqExt    = MAX_REQ'(req);
  assign w_arbIdx    = IDW'(prio_enc(w_reqExt));
  assign w_lowerMask = (NUM_REQ'(1) << r_owner) - NUM_REQ'(1);
  assign w_higherReq = |(req & w_lowerMask);
  assign w_ownerReq  = req[r_owner];

  down_timer #(.WIDTH(TW)) u_holdTimer (
    .i_clk     (clock_25mhz),
    .i_rstN    (reset_n),
    .i_load    (w_holdLoad),
    .i_loadVal (HOLD_LOAD),
    .i_tick    (r_state == ST_OWN),
    .o_expired (w_holdExpired)
  );

  down_timer #(.WIDTH(TW)) u_gapTimer (
    .i_clk     (clock_25mhz),
    .i_rstN    (reset_n),
    .i_load    (w_gapLoad),
    .i_loadVal (GAP_LOAD),
    .i_tick    (r_state == ST_GAP),
    .o_expired (w_gapExpired)
  );

  // Outputs are derived from the next state so every output is a flop yet
  // still appears one edge after the decision that caused it.
  always_comb begin
    w_nextState   = r_state;
    w_nextOwner   = r_owner;
    w_holdLoad    = 1'b0;
    w_gapLoad     = 1'b0;
    w_nextGrant   = '0;
    w_nextGrantId = '0;
    w_nextBusy    = 1'b0;
    w_nextAudio   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_nextState = ST_OWN;
          w_nextOwner = w_arbIdx;
          w_holdLoad  = 1'b1;
        end
      end
      ST_OWN: begin
        if (!w_ownerReq || (w_holdExpired && w_higherReq)) begin
          w_nextState = ST_GAP;
          w_gapLoad   = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_gapExpired) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase

    if (w_nextState == ST_OWN) begin
      w_nextGrant   = NUM_REQ'(1) << w_nextOwner;
      w_nextGrantId = w_nextOwner;
      w_nextAudio   = tone_in[w_nextOwner];
    end
    w_nextBusy = (w_nextState != ST_IDLE);
  end

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_grant   <= '0;
      r_grantId <= '0;
      r_busy    <= 1'b0;
      r_audio   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_owner   <= w_nextOwner;
      r_grant   <= w_nextGrant;
      r_grantId <= w_nextGrantId;
      r_busy    <= w_nextBusy;
      r_audio   <= w_nextAudio;
    end
  end

  assign grant     = r_grant;
  assign grant_id  = r_grantId;
  assign busy      = r_busy;
  assign audio_out = r_audio;

endmodule
